// File: rtl/btn_pkg.sv
// Shared constants and elaboration helpers for the push-button conditioner.
// Optional hold-to-repeat is selected at build time with BTN_AUTOREPEAT_EN.
package btn_pkg;

  localparam int unsigned DEF_CLK_HZ          = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_MS     = 10;
  localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
  localparam int unsigned DEF_REPEAT_RATE_MS  = 100;

  // Kind of debounced transition accepted on a tick.
  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  // Clock cycles per 1 ms tick; never below 1 so the divider stays well formed.
  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
  endfunction

  // Register width for a counter spanning n states, at least 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, tick-based debounce, registered edge pulses and,
// when BTN_AUTOREPEAT_EN is defined and enabled for this button, hold-to-repeat.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  input  logic i_ms_tick,
  output logic o_level,
  output logic o_pedge,
  output logic o_nedge
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_BUILD = 1'b1;
`else
  localparam bit REP_BUILD = 1'b0;
`endif
  localparam bit REP_ON = REP_BUILD && REPEAT_EN && (REPEAT_RATE_MS >= 1) &&
                          (REPEAT_RATE_MS <= REPEAT_DELAY_MS);

  localparam int unsigned     DB_W    = cnt_w(DEBOUNCE_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic            r_sync_meta;
  logic            r_sync;
  logic            r_level;
  logic            r_pedge;
  logic            r_nedge;
  logic [DB_W-1:0] r_db_cnt;

  logic  w_differs;
  logic  w_accept;
  logic  w_rep_pulse;
  edge_e w_edge;

  assign w_differs = (r_sync != r_level);
  // Acceptance happens on the tick whose increment would reach DEBOUNCE_MS.
  assign w_accept  = i_ms_tick && w_differs && (r_db_cnt == DB_LAST);

  always_comb begin
    w_edge = EDGE_NONE;
    if (w_accept) begin
      w_edge = r_sync ? EDGE_RISE : EDGE_FALL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_level     <= 1'b0;
      r_pedge     <= 1'b0;
      r_nedge     <= 1'b0;
      r_db_cnt    <= '0;
    end else begin
      r_sync_meta <= i_raw;
      r_sync      <= r_sync_meta;
      r_pedge     <= (w_edge == EDGE_RISE) || w_rep_pulse;
      r_nedge     <= (w_edge == EDGE_FALL);
      if (i_ms_tick) begin
        if (!w_differs || w_accept) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
      if (w_accept) begin
        r_level <= r_sync;
      end
    end
  end

  if (REP_ON) begin : g_repeat
    localparam int unsigned       HOLD_W      = cnt_w(REPEAT_DELAY_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_hit;

    // A release accepted on the same tick wins over a repeat that would coincide.
    assign w_hold_hit  = i_ms_tick && r_level && !w_accept && (r_hold_cnt == HOLD_LAST);
    assign w_rep_pulse = w_hold_hit;

    always_ff @(posedge i_clk) begin
      if (!i_reset_n || w_accept || !r_level) begin
        r_hold_cnt <= '0;
      end else if (w_hold_hit) begin
        r_hold_cnt <= HOLD_RELOAD;
      end else if (i_ms_tick) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end else begin : g_no_repeat
    assign w_rep_pulse = 1'b0;
  end

  assign o_level = r_level;
  assign o_pedge = r_pedge;
  assign o_nedge = r_nedge;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: shared 1 ms tick divider feeding N_BTN debounce channels.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat on buttons selected by REPEAT_MASK.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned       N_BTN           = 3,
  parameter int unsigned       CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned       DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int unsigned       REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int unsigned       REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 3'b110
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pedge,
  output logic [N_BTN-1:0] btn_nedge
);

  localparam int unsigned      MS_DIV   = ms_div(CLK_HZ);
  localparam int unsigned      DIV_W    = cnt_w(MS_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_ms_tick;

  assign w_ms_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_ms_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .REPEAT_EN       (REPEAT_MASK[gi])
    ) u_ch (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_raw     (btn_raw[gi]),
      .i_ms_tick (w_ms_tick),
      .o_level   (btn_level[gi]),
      .o_pedge   (btn_pedge[gi]),
      .o_nedge   (btn_nedge[gi])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner at CLK_HZ=10_000 (10 cycles per ms), DEBOUNCE_MS=4.
// Expected repeat pulses are added only when BTN_AUTOREPEAT_EN is defined.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_pedge;
  logic [2:0] btn_nedge;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    string      name;
    logic [2:0] pedge;
    logic [2:0] nedge;
    logic [2:0] level;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];

  btn_conditioner #(
    .N_BTN           (3),
    .CLK_HZ          (10_000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (5),
    .REPEAT_MASK     (3'b110)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pedge (btn_pedge),
    .btn_nedge (btn_nedge)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic expect_evt(input string nm, input logic [2:0] p, input logic [2:0] n,
                            input logic [2:0] l, input int lo, input int hi);
    exp_t e;
    e.name  = nm;
    e.pedge = p;
    e.nedge = n;
    e.level = l;
    e.lo    = lo;
    e.hi    = hi;
    sb.push_back(e);
  endtask

  task automatic set_btn(input logic [2:0] v, output int t);
    @(posedge clk);
    #1;
    btn_raw = v;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: every pulse cycle must match the oldest expectation, inside its window.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((btn_pedge | btn_nedge) != 3'b000) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: actual pedge=%b nedge=%b at cycle %0d, required no pulse",
                   btn_pedge, btn_nedge, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_pedge"}, btn_pedge, e.pedge);
          chk({e.name, "_nedge"}, btn_nedge, e.nedge);
          chk({e.name, "_level"}, btn_level, e.level);
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            failures++;
            $display("FAIL %s_time: actual cycle=%0d required %0d..%0d", e.name, cyc, e.lo, e.hi);
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].hi) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: actual no pulse by cycle %0d required pedge=%b nedge=%b",
                 sb[0].name, cyc, sb[0].pedge, sb[0].nedge);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int t;
    int t1;
    int r;
    btn_raw = 3'b000;
    reset_n = 1'b0;
    idle(3);
    @(negedge clk);
    chk("reset_level", btn_level, 3'b000);
    chk("reset_pedge", btn_pedge, 3'b000);
    chk("reset_nedge", btn_nedge, 3'b000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(50);

    // Clean press and release of btn[1]
    set_btn(3'b010, t);
    expect_evt("press1", 3'b010, 3'b000, 3'b010, t + 33, t + 43);
    idle(99);
    set_btn(3'b000, t);
    expect_evt("release1", 3'b000, 3'b010, 3'b000, t + 33, t + 43);
    idle(80);

    // Bounce every 15 cycles, then settle high
    for (int k = 0; k < 4; k++) begin
      set_btn((k % 2 == 0) ? 3'b010 : 3'b000, t);
      idle(14);
    end
    set_btn(3'b010, t1);
    expect_evt("bounce_press1", 3'b010, 3'b000, 3'b010, t1 + 33, t1 + 43);
    idle(60);

    // 20-cycle low glitch while held must be ignored
    set_btn(3'b000, t);
    idle(19);
    set_btn(3'b010, t);
    idle(60);
    set_btn(3'b000, t);
    expect_evt("release1b", 3'b000, 3'b010, 3'b000, t + 33, t + 43);
    idle(80);

    // btn[0] accepted, then reset lands mid-way through a btn[2] debounce
    set_btn(3'b001, t);
    expect_evt("press0", 3'b001, 3'b000, 3'b001, t + 33, t + 43);
    idle(60);
    set_btn(3'b101, t);
    idle(24);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
    @(negedge clk);
    chk("midreset_level", btn_level, 3'b000);
    chk("midreset_pedge", btn_pedge, 3'b000);
    chk("midreset_nedge", btn_nedge, 3'b000);
    expect_evt("reheld", 3'b101, 3'b000, 3'b101, r + 33, r + 43);
    idle(80);
    set_btn(3'b000, t);
    expect_evt("release02", 3'b000, 3'b101, 3'b000, t + 33, t + 43);
    idle(80);

    // Simultaneous press of btn[0] and btn[2], held 40 ms
    set_btn(3'b101, t);
    expect_evt("simul_press", 3'b101, 3'b000, 3'b101, t + 33, t + 43);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) begin
      expect_evt("repeat2", 3'b100, 3'b000, 3'b101, t + 233 + 50 * k, t + 243 + 50 * k);
    end
`endif
    idle(399);
    set_btn(3'b000, t1);
    expect_evt("simul_release", 3'b000, 3'b101, 3'b000, t1 + 33, t1 + 43);
    idle(80);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_events: actual %0d outstanding required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
